uart_text_writer: RTL and testbench
===================================

UART_TEXT_WRITER -- requirements
Module: uart_text_writer

Interface
REQ-001 Parameter COLS, default 32: text columns; power of two.
REQ-002 Parameter ROWS, default 8: text rows; power of two.
REQ-003 Parameter ADDR_W, default 8: RAM address width; SHALL equal log2(COLS*ROWS).
REQ-004 clk  in  1  system clock; one clock domain only.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_wr  in  1  received-byte strobe from the UART receiver.
REQ-007 i_data  in  8  received byte; valid only while i_wr=1.
REQ-008 o_busy  out  1  high while a clear sequence is running; bytes are not accepted.
REQ-009 o_drop  out  1  one-cycle pulse when a byte arrives while o_busy=1.
REQ-010 o_ram_we  out  1  write strobe to the text RAM write port.
REQ-011 o_ram_addr  out  ADDR_W  write address, equal to {row, col}.
REQ-012 o_ram_din  out  8  character to write.
REQ-013 o_cur_row / o_cur_col  out  log2(ROWS) / log2(COLS)  current cursor position.

Function
REQ-014 All outputs SHALL be registered.
- States: CLR_ALL, IDLE, CLR_LINE.
REQ-015 A byte is accepted when i_wr=1 and state is IDLE; o_busy=0 exactly in IDLE.
REQ-016 i_wr=1 outside IDLE SHALL drop the byte, pulse o_drop the next cycle, and leave the cursor and state unchanged.
REQ-017 Printable byte (0x20..0x7E) accepted in cycle N:
- Cycle N+1: o_ram_we=1, o_ram_addr={row,col}, o_ram_din=byte.
- Then col increments.
- Back-to-back printable bytes SHALL be accepted every cycle.
REQ-018 If col was COLS-1 when a printable byte is written, col SHALL become 0 and a newline (REQ-020) SHALL follow in the same cycle.
REQ-019 CR 0x0D sets col=0; no RAM write.
REQ-020 LF 0x0A, or newline after wrap:
- row becomes (row+1) mod ROWS.
- State enters CLR_LINE for the new row.
REQ-021 CLR_LINE SHALL write 0x20 to the COLS addresses of the cursor row, in ascending order, one per cycle, then return to IDLE; o_busy=1 for exactly those COLS cycles.
REQ-022 BS 0x08:
- If col>0: col decrements, and the next cycle writes 0x20 at the new position.
- If col=0: no action.
REQ-023 FF 0x0C SHALL set the cursor to (0,0) and enter CLR_ALL.
REQ-024 CLR_ALL SHALL write 0x20 to addresses 0..COLS*ROWS-1 in ascending order, one per cycle, with o_busy=1, then enter IDLE.
REQ-025 All other bytes (0x00..0x1F except those above, and 0x7F..0xFF) SHALL be ignored with no write and no cursor change.
REQ-026 Address counters SHALL wrap modulo 2^ADDR_W; no out-of-range write is permitted.
REQ-027 o_ram_we SHALL be 0 in every cycle not specified above.

Reset
REQ-028 While reset_n=0:
- o_ram_we=0, o_ram_addr=0, o_ram_din=0x20.
- Cursor at (0,0); o_drop=0; o_busy=1.
- State is CLR_ALL with its counter at 0.
REQ-029 After reset_n rises, the full-screen clear of REQ-024 SHALL run (COLS*ROWS cycles) before any byte is accepted.
REQ-030 Asserting reset_n mid-sequence SHALL abort the sequence immediately; the next write SHALL be address 0 of a new CLR_ALL.

Verification
REQ-031 Reset release -> 256 writes of 0x20 at addresses 0..255, o_busy high for 256 cycles, then o_busy=0 and cursor (0,0).
REQ-032 Bytes "A","B" on consecutive cycles -> writes (0x00,0x41) then (0x01,0x42); cursor (0,2).
REQ-033 33 printable bytes from (0,0) -> 32 writes on row 0, then 32 clear writes at 0x20..0x3F; the 33rd byte arrives during the clear, so o_drop pulses and the cursor stays (1,0).
REQ-034 Cursor (7,5), then LF -> row wraps to 0, addresses 0x00..0x1F cleared, cursor (0,5); CR then gives (0,0).
REQ-035 Cursor (0,3), then BS -> write (0x02,0x20), cursor (0,2); BS at col 0 -> no write.
REQ-036 FF mid-line, then reset_n pulsed low at clear count 100 -> clear restarts from address 0; bytes 0x01 and 0xFF produce no writes.

Source files
------------

// File: rtl/uart_text_writer.sv
// Turns a received UART byte stream into writes on a COLS x ROWS text RAM,
// handling printable bytes, CR, LF, BS and FF plus line and screen clears.
//
// Ports:
//   clk, reset_n          clock; asynchronous active-low reset
//   i_wr, i_data          received byte strobe and byte
//   o_busy                high while a line or screen clear is running
//   o_drop                one-cycle pulse for a byte that arrived while busy
//   o_ram_we/addr/din     text RAM write port, addr = {row, col}
//   o_cur_row, o_cur_col  current cursor position
module uart_text_writer #(
    parameter int COLS   = 32,
    parameter int ROWS   = 8,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_wr,
    input  logic [7:0]              i_data,
    output logic                    o_busy,
    output logic                    o_drop,
    output logic                    o_ram_we,
    output logic [ADDR_W-1:0]       o_ram_addr,
    output logic [7:0]              o_ram_din,
    output logic [$clog2(ROWS)-1:0] o_cur_row,
    output logic [$clog2(COLS)-1:0] o_cur_col
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [1:0] {
        CLR_ALL,
        IDLE,
        CLR_LINE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;

    logic is_print;
    logic is_cr;
    logic is_lf;
    logic is_bs;
    logic is_ff;

    always_comb begin
        is_print = (i_data >= 8'h20) && (i_data <= 8'h7E);
        is_cr    = (i_data == 8'h0D);
        is_lf    = (i_data == 8'h0A);
        is_bs    = (i_data == 8'h08);
        is_ff    = (i_data == 8'h0C);
    end

    assign o_cur_row = row;
    assign o_cur_col = col;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLR_ALL;
            cnt        <= '0;
            row        <= '0;
            col        <= '0;
            o_busy     <= 1'b1;
            o_drop     <= 1'b0;
            o_ram_we   <= 1'b0;
            o_ram_addr <= '0;
            o_ram_din  <= SPACE;
        end else begin
            o_ram_we <= 1'b0;
            o_drop   <= 1'b0;
            case (state)
                CLR_ALL: begin
                    o_drop     <= i_wr;
                    o_ram_we   <= 1'b1;
                    o_ram_addr <= cnt;
                    o_ram_din  <= SPACE;
                    // counter wraps back to 0 on the last address
                    cnt        <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                CLR_LINE: begin
                    o_drop     <= i_wr;
                    o_ram_we   <= 1'b1;
                    o_ram_addr <= ADDR_W'({row, cnt[CW-1:0]});
                    o_ram_din  <= SPACE;
                    if (cnt[CW-1:0] == COL_MAX) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (i_wr) begin
                        unique case (1'b1)
                            is_print: begin
                                o_ram_we   <= 1'b1;
                                o_ram_addr <= ADDR_W'({row, col});
                                o_ram_din  <= i_data;
                                if (col == COL_MAX) begin
                                    // wrap: implicit newline
                                    col    <= '0;
                                    row    <= row + 1'b1;
                                    cnt    <= '0;
                                    state  <= CLR_LINE;
                                    o_busy <= 1'b1;
                                end else begin
                                    col <= col + 1'b1;
                                end
                            end
                            is_cr: begin
                                col <= '0;
                            end
                            is_lf: begin
                                row    <= row + 1'b1;
                                cnt    <= '0;
                                state  <= CLR_LINE;
                                o_busy <= 1'b1;
                            end
                            is_bs: begin
                                if (col != '0) begin
                                    col        <= col - 1'b1;
                                    o_ram_we   <= 1'b1;
                                    o_ram_addr <= ADDR_W'({row, col - 1'b1});
                                    o_ram_din  <= SPACE;
                                end
                            end
                            is_ff: begin
                                row    <= '0;
                                col    <= '0;
                                cnt    <= '0;
                                state  <= CLR_ALL;
                                o_busy <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                default: begin
                    state  <= CLR_ALL;
                    cnt    <= '0;
                    o_busy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_text_writer.sv
// Directed bench for uart_text_writer: captures every RAM write and
// checks it against hand-computed sequences with immediate assertions.
module tb_uart_text_writer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_wr = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_busy;
    logic       o_drop;
    logic       o_ram_we;
    logic [7:0] o_ram_addr;
    logic [7:0] o_ram_din;
    logic [2:0] o_cur_row;
    logic [4:0] o_cur_col;

    int n_chk = 0;
    int n_fail = 0;
    int drop_cnt = 0;
    logic [15:0] wq[$];

    uart_text_writer #(.COLS(32), .ROWS(8), .ADDR_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_wr       (i_wr),
        .i_data     (i_data),
        .o_busy     (o_busy),
        .o_drop     (o_drop),
        .o_ram_we   (o_ram_we),
        .o_ram_addr (o_ram_addr),
        .o_ram_din  (o_ram_din),
        .o_cur_row  (o_cur_row),
        .o_cur_col  (o_cur_col)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_ram_we === 1'b1) wq.push_back({o_ram_addr, o_ram_din});
        if (o_drop === 1'b1) drop_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        i_wr   = 1'b1;
        i_data = b;
        @(negedge clk);
        i_wr   = 1'b0;
        i_data = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (o_busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check(tag, 32'(n), 32'd0);
    endtask

    task automatic send_wait(input logic [7:0] b);
        send(b);
        wait_ready("busy_timeout");
        idle(1);
    endtask

    // Checks a full-screen clear following a reset release.
    task automatic check_full_clear(input string tag);
        int n = 0;
        int bad = 0;
        while (o_busy === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        idle(1);
        check({tag, "_busy_cycles"}, 32'(n), 32'd256);
        check({tag, "_writes"}, 32'(wq.size()), 32'd256);
        for (int i = 0; i < wq.size(); i++)
            if (wq[i] !== {8'(i), 8'h20}) bad++;
        check({tag, "_write_content"}, 32'(bad), 32'd0);
        check({tag, "_cursor"}, {o_cur_row, o_cur_col}, 8'h00);
    endtask

    initial begin
        int bad;

        // reset state
        idle(3);
        check("rst_we", o_ram_we, 1'b0);
        check("rst_addr", o_ram_addr, 8'h00);
        check("rst_din", o_ram_din, 8'h20);
        check("rst_busy", o_busy, 1'b1);
        check("rst_drop", o_drop, 1'b0);
        check("rst_cursor", {o_cur_row, o_cur_col}, 8'h00);

        // power-up clear
        wq.delete();
        reset_n = 1'b1;
        check_full_clear("init");

        // "A","B" back to back
        wq.delete();
        send(8'h41);
        send(8'h42);
        idle(2);
        check("ab_count", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            check("ab_w0", wq[0], 16'h0041);
            check("ab_w1", wq[1], 16'h0142);
        end
        check("ab_cursor", {o_cur_row, o_cur_col}, {3'd0, 5'd2});

        // 33 printable bytes from (0,0): wrap, line clear, last dropped
        send(8'h0D);
        idle(1);
        check("cr_cursor", {o_cur_row, o_cur_col}, 8'h00);
        wq.delete();
        drop_cnt = 0;
        for (int i = 0; i < 33; i++) send(8'(8'h30 + i));
        wait_ready("wrap_timeout");
        idle(2);
        check("wrap_count", 32'(wq.size()), 32'd64);
        bad = 0;
        for (int i = 0; i < wq.size() && i < 64; i++) begin
            if (i < 32 && wq[i] !== {8'(i), 8'(8'h30 + i)}) bad++;
            if (i >= 32 && wq[i] !== {8'(i), 8'h20}) bad++;
        end
        check("wrap_content", 32'(bad), 32'd0);
        check("wrap_drop", 32'(drop_cnt), 32'd1);
        check("wrap_cursor", {o_cur_row, o_cur_col}, {3'd1, 5'd0});

        // reach (7,5), then LF wraps to row 0
        for (int i = 0; i < 6; i++) send_wait(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h78);
        idle(1);
        check("pre_lf_cursor", {o_cur_row, o_cur_col}, {3'd7, 5'd5});
        wq.delete();
        send_wait(8'h0A);
        check("lf_count", 32'(wq.size()), 32'd32);
        bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i] !== {8'(i), 8'h20}) bad++;
        check("lf_content", 32'(bad), 32'd0);
        check("lf_cursor", {o_cur_row, o_cur_col}, {3'd0, 5'd5});
        send(8'h0D);
        idle(1);
        check("lf_cr_cursor", {o_cur_row, o_cur_col}, 8'h00);

        // backspace
        send(8'h61);
        send(8'h62);
        send(8'h63);
        idle(2);
        check("bs_pre_cursor", {o_cur_row, o_cur_col}, {3'd0, 5'd3});
        wq.delete();
        send(8'h08);
        idle(2);
        check("bs_count", 32'(wq.size()), 32'd1);
        if (wq.size() == 1) check("bs_write", wq[0], 16'h0220);
        check("bs_cursor", {o_cur_row, o_cur_col}, {3'd0, 5'd2});
        send(8'h0D);
        idle(1);
        wq.delete();
        send(8'h08);
        idle(2);
        check("bs0_count", 32'(wq.size()), 32'd0);
        check("bs0_cursor", {o_cur_row, o_cur_col}, 8'h00);

        // FF mid-line, then reset at clear count 100
        send(8'h51);
        send(8'h52);
        idle(2);
        wq.delete();
        send(8'h0C);
        check("ff_busy", o_busy, 1'b1);
        check("ff_cursor", {o_cur_row, o_cur_col}, 8'h00);
        bad = 0;
        while (wq.size() < 100 && bad < 500) begin
            @(negedge clk);
            bad++;
        end
        check("ff_progress", 32'(wq.size()), 32'd100);
        if (wq.size() >= 100) check("ff_w99", wq[99], 16'h6320);
        reset_n = 1'b0;
        #1;
        check("mid_rst_we", o_ram_we, 1'b0);
        check("mid_rst_addr", o_ram_addr, 8'h00);
        check("mid_rst_busy", o_busy, 1'b1);
        @(negedge clk);
        wq.delete();
        reset_n = 1'b1;
        check_full_clear("rerun");

        // ignored bytes
        wq.delete();
        send(8'h01);
        send(8'hFF);
        send(8'h7F);
        idle(2);
        check("ignore_count", 32'(wq.size()), 32'd0);
        check("ignore_cursor", {o_cur_row, o_cur_col}, 8'h00);
        check("ignore_busy", o_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
